// File: rtl/ecc_scrub_ctrl_if.sv
// Host and cell-array signals for the ECC scrub controller.
// master = host/cell side, slave = controller side.
interface ecc_scrub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             rd_req;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] cell_inp;
    logic [WIDTH-1:0] cell_val;
    logic [WIDTH-1:0] cell_err;

    modport master (
        output wr_en, wr_data, rd_req, cell_val, cell_err,
        input  wr_ready, rd_valid, rd_data, cell_inp
    );

    modport slave (
        input  wr_en, wr_data, rd_req, cell_val, cell_err,
        output wr_ready, rd_valid, rd_data, cell_inp
    );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// ECC scrub controller: owns the word re-latched by a row of ecc_mem_bit
// cells, gives the host a write/read port, and rewrites the corrected word
// whenever any cell flags an error. Counts successful scrubs, raises irq,
// and sets a sticky fault when retries run out.
module ecc_scrub_ctrl #(
    parameter int WIDTH        = 8,
    parameter int WRITE_CYCLES = 2,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    ecc_scrub_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] err_count,
    output logic             irq,
    input  logic             irq_ack,
    output logic             fault
);
    localparam int CYC_W = $clog2(WRITE_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WRITE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, WRITE, SCRUB, CHECK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] cinp_q, cinp_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;
    logic             fault_q, fault_d;
    logic             pend_q, pend_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             any_err;
    logic             scrub_ok;

    assign any_err = |bus.cell_err;

    // State and datapath registers; reset aborts any write/scrub in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            cinp_q     <= '0;
            cyc_q      <= '0;
            retry_q    <= '0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
            fault_q    <= 1'b0;
            pend_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cinp_q     <= cinp_d;
            cyc_q      <= cyc_d;
            retry_q    <= retry_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
            fault_q    <= fault_d;
            pend_q     <= pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next-state: write/scrub sequencing, retry/fault decision, read service.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cinp_d     = cinp_q;
        cyc_d      = cyc_q;
        retry_d    = retry_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        pend_d     = pend_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        scrub_ok   = 1'b0;

        case (state_q)
            IDLE: begin
                cinp_d = hold_q;
                // Host write takes priority over a pending error.
                if (bus.wr_en) begin
                    state_d = WRITE;
                    hold_d  = bus.wr_data;
                    cinp_d  = bus.wr_data;
                    cyc_d   = '0;
                end else if (any_err) begin
                    state_d = SCRUB;
                    hold_d  = bus.cell_val;
                    cinp_d  = bus.cell_val;
                    retry_d = RTY_W'(1);
                    cyc_d   = '0;
                end
            end
            WRITE: begin
                if (cyc_q == CYC_LAST) state_d = IDLE;
                else                   cyc_d   = cyc_q + CYC_W'(1);
            end
            SCRUB: begin
                if (cyc_q == CYC_LAST) state_d = CHECK;
                else                   cyc_d   = cyc_q + CYC_W'(1);
            end
            CHECK: begin
                if (!any_err) begin
                    state_d  = IDLE;
                    scrub_ok = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end else if (retry_q < RTY_MAX) begin
                    state_d = SCRUB;
                    hold_d  = bus.cell_val;
                    cinp_d  = bus.cell_val;
                    retry_d = retry_q + RTY_W'(1);
                    cyc_d   = '0;
                end else begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reads are served only from IDLE; one pending request is remembered.
        if (state_q == IDLE && (bus.rd_req || pend_q)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = hold_q;
            pend_d     = 1'b0;
        end else if (bus.rd_req) begin
            pend_d = 1'b1;
        end
    end

    // A successful scrub setting irq wins over a same-cycle ack.
    assign irq_d = scrub_ok | (irq_q & ~irq_ack);

    assign bus.wr_ready = (state_q == IDLE);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.cell_inp = cinp_q;
    assign err_count    = cnt_q;
    assign irq          = irq_q;
    assign fault        = fault_q;
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl with a read-data scoreboard queue.
module tb_ecc_scrub_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             irq_ack;
    logic [CNT_W-1:0] err_count;
    logic             irq;
    logic             fault;

    ecc_scrub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    ecc_scrub_ctrl #(
        .WIDTH(WIDTH), .WRITE_CYCLES(2), .MAX_RETRY(3), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .err_count (err_count),
        .irq       (irq),
        .irq_ack   (irq_ack),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         exp_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; irq_ack = 1'b0;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0;
        bus.cell_val = '0; bus.cell_err = '0;
        tick(2);
        n_chk++;
        if ({bus.cell_inp, bus.rd_data, err_count, bus.rd_valid, irq, fault, bus.wr_ready}
            !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state got inp=%h rd=%h cnt=%h v=%b irq=%b f=%b rdy=%b",
                     bus.cell_inp, bus.rd_data, err_count, bus.rd_valid, irq, fault, bus.wr_ready);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_write_read;
        int lo;
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick(1);
        bus.wr_en = 1'b0;
        lo = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.wr_ready) break;
            lo++;
            tick(1);
        end
        n_chk++;
        if (lo !== 2) begin n_fail++; $display("FAIL write_busy_cycles got %0d want 2", lo); end
        tick(4);
        bus.rd_req = 1'b1; exp_q.push_back(8'hA5);
        tick(1);
        bus.rd_req = 1'b0;
        n_chk++;
        if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_latency got rd_valid=%b want 1", bus.rd_valid); end
        else begin
            e = exp_q.pop_front(); n_chk++;
            if (bus.rd_data !== e) begin n_fail++; $display("FAIL sb_rd_data got %h want %h", bus.rd_data, e); end
        end
        tick(1);
        n_chk++;
        if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_single got 1 want 0"); end
        n_chk++;
        if (bus.cell_inp !== 8'hA5 || err_count !== 8'h00) begin
            n_fail++; $display("FAIL write_outputs got inp=%h cnt=%h want a5/00", bus.cell_inp, err_count);
        end
    endtask

    task automatic test_scrub;
        bus.cell_val = 8'hA5; bus.cell_err = 8'h08;
        tick(1);
        bus.cell_err = 8'h00;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (bus.cell_inp !== 8'hA5 || bus.wr_ready !== 1'b0) begin
                n_fail++; $display("FAIL scrub_hold[%0d] got inp=%h rdy=%b want a5/0", i, bus.cell_inp, bus.wr_ready);
            end
            tick(1);
        end
        tick(1);
        exp_cnt = 1;
        n_chk++;
        if (err_count !== 8'(exp_cnt) || irq !== 1'b1 || bus.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL scrub_done got cnt=%h irq=%b rdy=%b want %h/1/1", err_count, irq, bus.wr_ready, 8'(exp_cnt));
        end
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        n_chk++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ack got irq=%b want 0", irq); end
    endtask

    task automatic test_fault;
        int n, lo;
        bus.cell_val = 8'hA5; bus.cell_err = 8'h01;
        n = 0; lo = 0;
        while (n < 60) begin
            tick(1);
            n++;
            if (fault) break;
            if (!bus.wr_ready) lo++;
        end
        bus.cell_err = 8'h00;
        n_chk++;
        if (n !== 10) begin n_fail++; $display("FAIL fault_latency got %0d edges want 10", n); end
        n_chk++;
        if (lo !== 9) begin n_fail++; $display("FAIL fault_busy_cycles got %0d want 9 (3 passes)", lo); end
        n_chk++;
        if (err_count !== 8'(exp_cnt) || irq !== 1'b0) begin
            n_fail++; $display("FAIL fault_no_count got cnt=%h irq=%b want %h/0", err_count, irq, 8'(exp_cnt));
        end
        tick(6);
        n_chk++;
        if (fault !== 1'b1 || bus.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL fault_sticky got fault=%b rdy=%b want 1/1", fault, bus.wr_ready);
        end
    endtask

    task automatic test_same_cycle;
        bus.wr_en = 1'b1; bus.wr_data = 8'h3C; bus.cell_val = 8'hA5; bus.cell_err = 8'h01;
        tick(1);
        bus.wr_en = 1'b0; bus.cell_err = 8'h00;
        n_chk++;
        if (bus.cell_inp !== 8'h3C) begin n_fail++; $display("FAIL wr_wins_inp got %h want 3c", bus.cell_inp); end
        tick(3);
        bus.rd_req = 1'b1; exp_q.push_back(8'h3C);
        tick(1);
        bus.rd_req = 1'b0;
        n_chk++;
        if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL wr_wins_rd got rd_valid=%b want 1", bus.rd_valid); end
        else begin
            e = exp_q.pop_front(); n_chk++;
            if (bus.rd_data !== e) begin n_fail++; $display("FAIL sb_rd_data got %h want %h", bus.rd_data, e); end
        end
        n_chk++;
        if (err_count !== 8'(exp_cnt) || irq !== 1'b0) begin
            n_fail++; $display("FAIL wr_wins_count got cnt=%h irq=%b want %h/0", err_count, irq, 8'(exp_cnt));
        end
    endtask

    task automatic test_read_during_scrub;
        bus.cell_val = 8'h5A; bus.cell_err = 8'h10;
        tick(1);
        bus.cell_err = 8'h00;
        bus.rd_req = 1'b1; exp_q.push_back(8'h5A);
        tick(1);
        bus.rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL pend_early[%0d] got rd_valid=1 want 0", i); end
            tick(1);
        end
        n_chk++;
        if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL pend_serve got rd_valid=%b want 1", bus.rd_valid); end
        else begin
            e = exp_q.pop_front(); n_chk++;
            if (bus.rd_data !== e) begin n_fail++; $display("FAIL sb_rd_data got %h want %h", bus.rd_data, e); end
        end
        tick(1);
        n_chk++;
        if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL pend_single got rd_valid=1 want 0"); end
        exp_cnt = 2;
        n_chk++;
        if (err_count !== 8'(exp_cnt) || irq !== 1'b1) begin
            n_fail++; $display("FAIL pend_scrub_cnt got cnt=%h irq=%b want %h/1", err_count, irq, 8'(exp_cnt));
        end
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
        tick(1);
        bus.wr_en = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_chk++;
        if ({bus.cell_inp, bus.rd_data, err_count, bus.rd_valid, irq, fault, bus.wr_ready}
            !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_write got inp=%h rd=%h cnt=%h v=%b irq=%b f=%b rdy=%b",
                     bus.cell_inp, bus.rd_data, err_count, bus.rd_valid, irq, fault, bus.wr_ready);
        end
        tick(2);
        n_chk++;
        if (bus.cell_inp !== 8'h00 || bus.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_relatch got inp=%h rdy=%b want 00/1", bus.cell_inp, bus.wr_ready);
        end
        exp_cnt = 0;
    endtask

    task automatic test_saturation;
        logic [7:0] last;
        last = 8'h00;
        for (int i = 1; i <= 260; i++) begin
            last = 8'($urandom);
            bus.cell_val = last;
            bus.cell_err = 8'(1 << (i % 8));
            tick(1);
            bus.cell_err = 8'h00;
            tick(3);
            if (exp_cnt < 255) exp_cnt++;
            if (i == 254 || i == 255 || i == 260) begin
                n_chk++;
                if (err_count !== 8'(exp_cnt)) begin
                    n_fail++; $display("FAIL sat_count[%0d] got %h want %h", i, err_count, 8'(exp_cnt));
                end
            end
        end
        n_chk++;
        if (irq !== 1'b1 || fault !== 1'b0) begin
            n_fail++; $display("FAIL sat_flags got irq=%b fault=%b want 1/0", irq, fault);
        end
        bus.rd_req = 1'b1; exp_q.push_back(last);
        tick(1);
        bus.rd_req = 1'b0;
        n_chk++;
        if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL sat_rd got rd_valid=%b want 1", bus.rd_valid); end
        else begin
            e = exp_q.pop_front(); n_chk++;
            if (bus.rd_data !== e) begin n_fail++; $display("FAIL sb_rd_data got %h want %h", bus.rd_data, e); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scrub();
        test_fault();
        test_same_cycle();
        test_read_during_scrub();
        test_reset_mid_write();
        test_saturation();
        n_chk++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL sb_leftover got %0d entries want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Controller that sits directly downstream of a word of WIDTH ecc_mem_bit cells and also drives their inp.
- Consumes each cell's val and err.
- Owns the value every cell re-latches each clk, so it gives the host a write/read port over the word.
- Scrubs automatically: rewrites the corrected word whenever any cell flags err.
- Counts corrections, raises a sticky fault if a scrub fails to clear err, and raises an interrupt to the CPU.

Parameters:
WIDTH, 8, bits per protected word (number of attached ecc_mem_bit cells)
WRITE_CYCLES, 2, clk cycles cell_inp is held at new data during a write/scrub (min 1)
MAX_RETRY, 3, scrub attempts before declaring fault (min 1)
CNT_W, 8, width of saturating correction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  host write request, accepted when wr_ready=1
wr_data  in  WIDTH  host write data
wr_ready  out  1  high only in IDLE
rd_req  in  1  host read request, single-cycle pulse
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  WIDTH  registered copy of hold word
cell_inp  out  WIDTH  drives inp of each ecc_mem_bit (registered)
cell_val  in  WIDTH  val from each cell
cell_err  in  WIDTH  err from each cell
err_count  out  CNT_W  successful scrubs, saturates at all-ones
irq  out  1  set on each successful scrub, level until acked
irq_ack  in  1  clears irq
fault  out  1  sticky: scrub retries exhausted, cleared only by rst

Behaviour:
- Reset is synchronous, active-high, one clock, one reset (clk, rst). On rst: state=IDLE, hold_q=0, cell_inp=0, rd_data=0, rd_valid=0, err_count=0, irq=0, fault=0, internal counters 0, pending read cleared. Reset mid-WRITE/SCRUB aborts; the cells relatch 0 on subsequent edges.
- cell_inp is always a registered output and never a combinational function of cell_val/cell_err (no loop through the cells). In IDLE, cell_inp=hold_q.
- States and transitions:
  - IDLE: wr_ready=1.
  - IDLE → WRITE: wr_en=1. On that edge hold_q<=wr_data and cell_inp<=wr_data.
  - IDLE → SCRUB: wr_en=0 and |cell_err=1. On that edge hold_q<=cell_val, cell_inp<=cell_val, retry<=1.
  - Write wins when wr_en and |cell_err occur in the same cycle; no count, no irq.
  - WRITE: held WRITE_CYCLES cycles (counter), then → IDLE. cell_err is ignored during WRITE.
  - SCRUB: held WRITE_CYCLES cycles, then evaluates on the following cycle (CHECK substate).
    - |cell_err=0 → IDLE; err_count+=1 (saturating); irq<=1.
    - |cell_err=1 and retry<MAX_RETRY → relatch hold_q<=cell_val, retry+=1, stay SCRUB.
    - |cell_err=1 and retry=MAX_RETRY → fault<=1 → IDLE. No count, no irq.
- Once fault=1, further errors still trigger scrub attempts. fault stays 1.
- Read:
  - rd_req in IDLE → rd_valid=1 and rd_data=hold_q on the next cycle (latency 1).
  - rd_req outside IDLE → latched pending. Served in the first IDLE cycle, rd_valid the cycle after.
  - Only one pending read; extra requests while pending merge.
  - rd_valid never asserts for two consecutive cycles from a single request.
- irq: irq_ack=1 clears irq unless a successful scrub sets it in the same cycle (set wins).
- wr_en while wr_ready=0 is ignored (not queued).

Test Plan:
1. rst, WIDTH=8; write 0xA5; wait 4 cycles; read → wr_ready low exactly 2 cycles; rd_valid pulse 1 cycle after rd_req with rd_data=0xA5; cell_inp=0xA5; err_count=0.
2. After storing 0xA5, force cell_err[3]=1 with cell_val=0xA5 for 1 cycle, then release → cell_inp=0xA5 held 2 cycles; then err_count=1, irq=1; irq_ack → irq=0 next cycle.
3. Hold cell_err[0]=1 permanently, MAX_RETRY=3 → exactly 3 scrub passes; then fault=1, err_count unchanged, irq=0; fault persists until rst.
4. Same cycle: wr_en with 0x3C and cell_err=0x01 in IDLE → WRITE taken, hold_q=0x3C, err_count=0, no irq.
5. rd_req during SCRUB → rd_valid exactly once, 1 cycle after return to IDLE, rd_data=corrected word.
6. Assert rst in 2nd WRITE cycle of 0xFF → next cycle all outputs 0, state IDLE; err_count saturates at 0xFF after 256+ scrubs (separate run).
